// File: rtl/hsi_mse_comp.sv
// Running min/max tracker for MSE results in the HSI spectral-identification path.
// Holds the smallest and largest unsigned MSE words seen since the last reset or clear.
module hsi_mse_comp #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  mse_in_valid,
    input  logic [WORD_WIDTH-1:0] mse_in,
    output logic                  mse_out_valid,
    output logic [WORD_WIDTH-1:0] mse_out_min,
    output logic [WORD_WIDTH-1:0] mse_out_max
);

    // rst_n is active-high despite its name; min starts at all ones so the first sample always wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mse_out_valid <= 1'b0;
            mse_out_min   <= '1;
            mse_out_max   <= '0;
        end else if (clear) begin
            mse_out_valid <= 1'b0;
            mse_out_min   <= '1;
            mse_out_max   <= '0;
        end else if (mse_in_valid) begin
            mse_out_valid <= 1'b1;
            if (mse_in <= mse_out_min) begin
                mse_out_min <= mse_in;
            end
            if (mse_in >= mse_out_max) begin
                mse_out_max <= mse_in;
            end
        end else begin
            mse_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hsi_mse_comp.sv
// Directed and randomised checks of the hsi_mse_comp running min/max tracker.
module tb_hsi_mse_comp;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          mse_in_valid;
    logic [W-1:0]  mse_in;
    logic          mse_out_valid;
    logic [W-1:0]  mse_out_min;
    logic [W-1:0]  mse_out_max;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] ref_min;
    logic [W-1:0] ref_max;
    logic         rnd_valid;
    logic [W-1:0] rnd_data;

    always #5 clk = ~clk;

    hsi_mse_comp #(.WORD_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .mse_in_valid  (mse_in_valid),
        .mse_in        (mse_in),
        .mse_out_valid (mse_out_valid),
        .mse_out_min   (mse_out_min),
        .mse_out_max   (mse_out_max)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic c, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        rst_n        = r;
        clear        = c;
        mse_in_valid = v;
        mse_in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic [W-1:0] emin, input logic [W-1:0] emax);
        checkOutput({tag, "_valid"}, {{(W-1){1'b0}}, mse_out_valid}, {{(W-1){1'b0}}, ev});
        checkOutput({tag, "_min"}, mse_out_min, emin);
        checkOutput({tag, "_max"}, mse_out_max, emax);
    endtask

    initial begin
        rst_n        = 1'b1;
        clear        = 1'b0;
        mse_in_valid = 1'b0;
        mse_in       = '0;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkAll("reset", 1'b0, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_007B);
        checkAll("reset_over_sample", 1'b0, 32'hFFFF_FFFF, 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_FFFF);
        checkAll("first_sample", 1'b1, 32'h0000_FFFF, 32'h0000_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checkAll("idle_hold", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h000F_FFFF);
        checkAll("new_max", 1'b1, 32'h0000_FFFF, 32'h000F_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0FFF);
        checkAll("new_min", 1'b1, 32'h0000_0FFF, 32'h000F_FFFF);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkAll("clear", 1'b0, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0005);
        checkAll("after_clear", 1'b1, 32'h0000_0005, 32'h0000_0005);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0007);
        checkAll("clear_drops_sample", 1'b0, 32'hFFFF_FFFF, 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkAll("all_ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        checkAll("zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        checkAll("equal_zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1234);
        checkAll("middle", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0009);
        checkAll("midstream_reset", 1'b0, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0000);
        checkAll("restart", 1'b1, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF);
        checkAll("unsigned_cmp", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        ref_min = 32'hFFFF_FFFF;
        ref_max = 32'h0;
        for (int i = 0; i < 50; i++) begin
            rnd_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                rnd_data = 32'($urandom_range(0, 255));
            end else begin
                rnd_data = $urandom;
            end
            applyStimulus(1'b0, 1'b0, rnd_valid, rnd_data);
            if (rnd_valid) begin
                if (rnd_data < ref_min) ref_min = rnd_data;
                if (rnd_data > ref_max) ref_max = rnd_data;
            end
            checkAll($sformatf("random_%0d", i), rnd_valid, ref_min, ref_max);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
